// File: rtl/conv_3x3_feeder_pkg.sv
// Shared types for the 3x3 convolution feeder: FSM encoding, kernel column count
// and a counter-width helper.
package conv_pkg;

  localparam int kernel_cols = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_K = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Bits needed to count 0..n-1 (minimum 1).
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/conv_3x3_feeder_if.sv
// Bundle between the pixel/kernel source (master) and the feeder (slave),
// including the feeder's FSM state for observation.
interface conv_3x3_feeder_if
  import conv_pkg::*;
#(
  parameter int input_width  = 8,
  parameter int weight_width = 8
);
  logic                      start;
  logic [9*weight_width-1:0] kernel_in;
  logic [input_width-1:0]    pix_in;
  logic                      pix_valid;
  logic                      pix_ready;
  logic [3*weight_width-1:0] kernel;
  logic                      kernel_valid;
  logic [3*input_width-1:0]  image;
  logic                      image_valid;
  logic                      input_last;
  logic                      frame_done;
  state_t                    state;

  // A pixel transfers on any rising clk edge where pix_valid && pix_ready; the
  // source may change pix_in freely while pix_ready is low. kernel/image are
  // pure valid-qualified pushes with no backpressure.
  modport master (
    output start, kernel_in, pix_in, pix_valid,
    input  pix_ready, kernel, kernel_valid, image, image_valid,
           input_last, frame_done, state
  );

  modport slave (
    input  start, kernel_in, pix_in, pix_valid,
    output pix_ready, kernel, kernel_valid, image, image_valid,
           input_last, frame_done, state
  );

endinterface

// File: rtl/conv_3x3_feeder_line_buffer.sv
// Two cascaded row delay lines; taps give the pixels one and two rows above
// the pixel currently being shifted in.
module conv_line_buffer #(
  parameter int depth = 32,
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [width-1:0] din,
  output logic [width-1:0] tap1,
  output logic [width-1:0] tap2
);

  logic [width-1:0] line1 [depth];
  logic [width-1:0] line2 [depth];

  // Contents are never cleared; the feeder masks stale rows via its row count.
  always_ff @(posedge clk) begin
    if (en) begin
      line1[0] <= din;
      line2[0] <= line1[depth-1];
      for (int i = 1; i < depth; i++) begin
        line1[i] <= line1[i-1];
        line2[i] <= line2[i-1];
      end
    end
  end

  assign tap1 = line1[depth-1];
  assign tap2 = line2[depth-1];

endmodule

// File: rtl/conv_3x3_feeder.sv
// Raster-to-column feeder for the 3x3 convolution PE. Define
// CONV_FEEDER_TOP_PAD_EN to emit rows 0 and 1 with zero top padding.
module conv_3x3_feeder
  import conv_pkg::*;
#(
  parameter int input_width  = 8,
  parameter int weight_width = 8,
  parameter int img_width    = 32,
  parameter int img_height   = 32
) (
  input  logic               clk,
  input  logic               rst,
  conv_3x3_feeder_if.slave   bus
);

  localparam int col_w = clog2(img_width);
  localparam int row_w = clog2(img_height + 1);
  localparam logic [col_w-1:0] col_last = col_w'(img_width - 1);
  localparam logic [row_w-1:0] row_last = row_w'(img_height - 1);
  localparam logic [1:0]       k_last   = 2'(kernel_cols - 1);

  state_t                    state_q, state_n;
  logic [1:0]                k_q;
  logic [9*weight_width-1:0] weights_q;
  logic [col_w-1:0]          col_q;
  logic [row_w-1:0]          row_q;
  logic [3*input_width-1:0]  image_q;
  logic                      image_valid_q, input_last_q, frame_done_q;

  logic                      accept, col_valid, is_last_pix;
  logic                      pix_ready_c, kernel_valid_c;
  logic [3*weight_width-1:0] kernel_c;
  logic [input_width-1:0]    tap1, tap2, up1, up2;

  assign accept      = bus.pix_valid && pix_ready_c;
  assign is_last_pix = (col_q == col_last) && (row_q == row_last);

  conv_line_buffer #(
    .depth (img_width),
    .width (input_width)
  ) u_line_buffer (
    .clk  (clk),
    .en   (accept),
    .din  (bus.pix_in),
    .tap1 (tap1),
    .tap2 (tap2)
  );

`ifdef CONV_FEEDER_TOP_PAD_EN
  assign up1       = (row_q >= row_w'(1)) ? tap1 : '0;
  assign up2       = (row_q >= row_w'(2)) ? tap2 : '0;
  assign col_valid = 1'b1;
`else
  assign up1       = tap1;
  assign up2       = tap2;
  assign col_valid = (row_q >= row_w'(2));
`endif

  always_comb begin
    state_n        = state_q;
    pix_ready_c    = 1'b0;
    kernel_valid_c = 1'b0;
    kernel_c       = '0;
    case (state_q)
      IDLE: if (bus.start) state_n = LOAD_K;
      LOAD_K: begin
        kernel_valid_c = 1'b1;
        kernel_c = {weights_q[(int'(k_q) + 6) * weight_width +: weight_width],
                    weights_q[(int'(k_q) + 3) * weight_width +: weight_width],
                    weights_q[int'(k_q) * weight_width +: weight_width]};
        if (k_q == k_last) state_n = STREAM;
      end
      STREAM: begin
        pix_ready_c = 1'b1;
        if (accept && is_last_pix) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      k_q           <= '0;
      weights_q     <= '0;
      col_q         <= '0;
      row_q         <= '0;
      image_q       <= '0;
      image_valid_q <= 1'b0;
      input_last_q  <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_n;
      image_valid_q <= 1'b0;
      input_last_q  <= 1'b0;
      // Registered so the pulse lands the cycle after the final column.
      frame_done_q  <= (state_q == DONE);
      if (state_q == IDLE && bus.start) begin
        weights_q <= bus.kernel_in;
        k_q       <= '0;
        col_q     <= '0;
        row_q     <= '0;
      end
      if (state_q == LOAD_K) k_q <= k_q + 2'd1;
      if (accept) begin
        if (col_q == col_last) begin
          col_q <= '0;
          row_q <= row_q + row_w'(1);
        end else begin
          col_q <= col_q + col_w'(1);
        end
        image_q       <= {bus.pix_in, up1, up2};
        image_valid_q <= col_valid;
        input_last_q  <= is_last_pix;
      end
    end
  end

  assign bus.pix_ready    = pix_ready_c;
  assign bus.kernel       = kernel_c;
  assign bus.kernel_valid = kernel_valid_c;
  assign bus.image        = image_q;
  assign bus.image_valid  = image_valid_q;
  assign bus.input_last   = input_last_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_conv_3x3_feeder.sv
// Directed bench for conv_3x3_feeder on a 4x4 frame with weights 1..9 and
// pixel value 4*row+col+1.
module tb_conv_3x3_feeder;
  import conv_pkg::*;

  localparam int iw = 8;
  localparam int ww = 8;
  localparam int W  = 4;
  localparam int H  = 4;
`ifdef CONV_FEEDER_TOP_PAD_EN
  localparam int n_cols = W * H;
`else
  localparam int n_cols = W * (H - 2);
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  conv_3x3_feeder_if #(.input_width(iw), .weight_width(ww)) bus ();

  conv_3x3_feeder #(
    .input_width  (iw),
    .weight_width (ww),
    .img_width    (W),
    .img_height   (H)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3*iw-1:0] exp_q[$];
  int   last_cyc  = -1;
  int   cols_seen = 0;
  logic acc_prev  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [iw-1:0] pix(input int r, input int c);
    return iw'(4 * r + c + 1);
  endfunction

  // Reference column list: {row r, row r-1, row r-2}, missing rows as zero.
  task automatic fill_expected();
    exp_q.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
`ifndef CONV_FEEDER_TOP_PAD_EN
        if (r < 2) continue;
`endif
        exp_q.push_back({pix(r, c),
                         (r >= 1) ? pix(r - 1, c) : iw'(0),
                         (r >= 2) ? pix(r - 2, c) : iw'(0)});
      end
  endtask

  // Scoreboard / monitor
  always @(negedge clk) begin
    logic [3*iw-1:0] e;
    if (bus.image_valid === 1'b1) begin
      check("valid_after_accept", acc_prev, 1);
      check("column_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("image", bus.image, e);
        check("input_last", bus.input_last, exp_q.size() == 0);
      end
      if (bus.input_last === 1'b1) last_cyc = cyc;
      cols_seen++;
    end else if (bus.input_last === 1'b1) begin
      check("last_needs_valid", bus.image_valid, 1);
    end
    acc_prev = (bus.pix_valid === 1'b1) && (bus.pix_ready === 1'b1);
  end

  // Drivers (entered and left just after a rising edge)
  task automatic do_start();
    logic [3*ww-1:0] ek;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ek = {ww'(7 + k), ww'(4 + k), ww'(1 + k)};
      check("kernel_valid", bus.kernel_valid, 1);
      check("kernel_col", bus.kernel, ek);
      check("ready_low_in_load", bus.pix_ready, 0);
      check("no_image_in_load", bus.image_valid, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("ready_after_load", bus.pix_ready, 1);
    check("kernel_valid_drop", bus.kernel_valid, 0);
    @(posedge clk); #1;
  endtask

  task automatic send_pixel(input logic [iw-1:0] v);
    logic ok;
    ok = 1'b0;
    bus.pix_valid = 1'b1;
    bus.pix_in    = v;
    for (int g = 0; g < 20 && !ok; g++) begin
      @(negedge clk);
      ok = bus.pix_ready;
      @(posedge clk); #1;
    end
    check("pix_accepted", ok, 1);
    bus.pix_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_image_valid"}, bus.image_valid, 0);
    check({tag, "_kernel_valid"}, bus.kernel_valid, 0);
    check({tag, "_pix_ready"}, bus.pix_ready, 0);
    check({tag, "_input_last"}, bus.input_last, 0);
    check({tag, "_frame_done"}, bus.frame_done, 0);
    check({tag, "_image"}, bus.image, 0);
    check({tag, "_state"}, bus.state, IDLE);
  endtask

  task automatic run_frame(input int gap, input int rst_after, input int start_at);
    logic found;
    fill_expected();
    last_cyc  = -1;
    cols_seen = 0;
    do_start();
    for (int idx = 0; idx < W * H; idx++) begin
      if (idx == rst_after) begin
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        exp_q.delete();
        @(posedge clk); #1;
        return;
      end
      if (gap != 0 && idx > 0) begin
        @(posedge clk); #1;
      end
      if (idx == start_at) bus.start = 1'b1;
      send_pixel(pix(idx / W, idx % W));
      if (idx == start_at) begin
        bus.start = 1'b0;
        @(negedge clk);
        check("start_ignored_kv", bus.kernel_valid, 0);
        check("start_ignored_state", bus.state, STREAM);
        @(posedge clk); #1;
      end
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) found = 1'b1;
    end
    check("frame_done_seen", found, 1);
    check("frame_done_delay", cyc - last_cyc, 1);
    check("state_back_idle", bus.state, IDLE);
    check("queue_drained", exp_q.size(), 0);
    check("column_count", cols_seen, n_cols);
    @(posedge clk); #1;
    check("frame_done_one_cycle", bus.frame_done, 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    for (int i = 0; i < 9; i++) bus.kernel_in[i*ww +: ww] = ww'(i + 1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;

    run_frame(0, -1, -1);  // back-to-back
    run_frame(1, -1, -1);  // gap every other cycle
    run_frame(0, 10, -1);  // reset after 10 pixels
    run_frame(0, -1, -1);  // clean frame after reset
    run_frame(0, -1, 5);   // start pulsed mid-stream

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
